// File: rtl/pipe_stage_regs_if.sv
// Pipeline boundary bundle between fetch/decode/hazard logic and the IF/ID + ID/EX register bank.
interface pipe_stage_regs_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 16
);
  logic              stall;
  logic              flush;
  logic [XLEN-1:0]   IF_pc;
  logic [31:0]       IF_inst;
  logic [XLEN-1:0]   ID_pc;
  logic [31:0]       ID_inst;
  logic              ID_valid;
  logic [CTRL_W-1:0] ID_ctrl;
  logic [4:0]        ID_rd;
  logic              ID_mem_read;
  logic [XLEN-1:0]   ID_rs1_data;
  logic [XLEN-1:0]   ID_rs2_data;
  logic [XLEN-1:0]   ID_imm;
  logic [XLEN-1:0]   EX_pc;
  logic [XLEN-1:0]   EX_rs1_data;
  logic [XLEN-1:0]   EX_rs2_data;
  logic [XLEN-1:0]   EX_imm;
  logic [CTRL_W-1:0] EX_ctrl;
  logic [4:0]        EX_rd;
  logic              EX_mem_read;
  logic              EX_valid;
  logic              pc_write;

  modport master (
    output stall, flush, IF_pc, IF_inst, ID_ctrl, ID_rd, ID_mem_read,
           ID_rs1_data, ID_rs2_data, ID_imm,
    input  ID_pc, ID_inst, ID_valid, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm,
           EX_ctrl, EX_rd, EX_mem_read, EX_valid, pc_write
  );

  modport slave (
    input  stall, flush, IF_pc, IF_inst, ID_ctrl, ID_rd, ID_mem_read,
           ID_rs1_data, ID_rs2_data, ID_imm,
    output ID_pc, ID_inst, ID_valid, EX_pc, EX_rs1_data, EX_rs2_data, EX_imm,
           EX_ctrl, EX_rd, EX_mem_read, EX_valid, pc_write
  );
endinterface

// File: rtl/pipe_stage_regs.sv
// IF/ID and ID/EX pipeline registers with load-use stall and branch flush handling.
// Optional stall/flush performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_regs #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CTRL_W   = 16,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_regs_if.slave bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  logic [XLEN-1:0]   id_pc_q;
  logic [31:0]       id_inst_q;
  logic              id_valid_q;
  logic [XLEN-1:0]   ex_pc_q;
  logic [XLEN-1:0]   ex_rs1_q;
  logic [XLEN-1:0]   ex_rs2_q;
  logic [XLEN-1:0]   ex_imm_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [4:0]        ex_rd_q;
  logic              ex_mem_read_q;
  logic              ex_valid_q;

  // IF/ID: bubble on reset/flush, hold on stall, otherwise capture fetch
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      id_pc_q    <= bus.IF_pc;
      id_inst_q  <= bus.IF_inst;
      id_valid_q <= 1'b1;
    end
  end

  // ID/EX: any of reset/flush/stall injects a bubble with rd=0 so it cannot retrigger a stall
  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.stall) begin
      ex_pc_q       <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_rd_q       <= 5'd0;
      ex_mem_read_q <= 1'b0;
      ex_valid_q    <= 1'b0;
    end else begin
      ex_pc_q       <= id_pc_q;
      ex_rs1_q      <= bus.ID_rs1_data;
      ex_rs2_q      <= bus.ID_rs2_data;
      ex_imm_q      <= bus.ID_imm;
      ex_ctrl_q     <= bus.ID_ctrl;
      ex_rd_q       <= bus.ID_rd;
      ex_mem_read_q <= bus.ID_mem_read;
      ex_valid_q    <= id_valid_q;
    end
  end

  assign bus.ID_pc       = id_pc_q;
  assign bus.ID_inst     = id_inst_q;
  assign bus.ID_valid    = id_valid_q;
  assign bus.EX_pc       = ex_pc_q;
  assign bus.EX_rs1_data = ex_rs1_q;
  assign bus.EX_rs2_data = ex_rs2_q;
  assign bus.EX_imm      = ex_imm_q;
  assign bus.EX_ctrl     = ex_ctrl_q;
  assign bus.EX_rd       = ex_rd_q;
  assign bus.EX_mem_read = ex_mem_read_q;
  assign bus.EX_valid    = ex_valid_q;

  // Branch target must be accepted even while a load-use stall is pending
  assign bus.pc_write = bus.flush | ~bus.stall;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; a combined stall+flush cycle counts as a flush only
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.stall && !bus.flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
